// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative data cache.
//   - cache_state_t : miss-handling FSM encoding (IDLE/WB/FILL/DONE)
//   - MEM_WORD_BYTES: bytes per memory/core word
//   - plru_width()  : tree-PLRU bits per set (WAY-1)
//   - way_bits()    : width of a way number (at least 1)
//   - addr_tag/addr_index/addr_word : byte-address field slicing
//   - line_addr()   : rebuilds a word-aligned byte address from its fields
package cache_pkg;

    localparam int MEM_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } cache_state_t;

    function automatic int plru_width(input int way);
        return way - 1;
    endfunction

    function automatic int way_bits(input int way);
        return (way > 1) ? $clog2(way) : 1;
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int offset);
        return (addr >> 2) & ((32'd1 << offset) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index,
                                               input int offset);
        return (addr >> (offset + 2)) & ((32'd1 << index) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index,
                                             input int offset);
        return addr >> (index + offset + 2);
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] idx,
                                              input logic [31:0] word, input int index,
                                              input int offset);
        return (tag << (index + offset + 2)) | (idx << (offset + 2)) | (word << 2);
    endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU replacement state.
//   clk, reset  : clock, asynchronous active-high reset (all trees cleared)
//   set_idx     : set being looked up / touched
//   touch       : mark touch_way most-recently used in set_idx at the next edge
//   touch_way   : way being touched
//   victim      : pseudo-LRU way of set_idx (combinational)
// Tree nodes are kept in heap order (children of node n are 2n+1, 2n+2).
// A node bit of 1 means the victim search goes to the right child.
// WAY=1 keeps no state and always reports way 0.
module cache_plru
    import cache_pkg::*;
#(
    parameter int WAY   = 2,
    parameter int INDEX = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [INDEX-1:0]          set_idx,
    input  logic                      touch,
    input  logic [way_bits(WAY)-1:0]  touch_way,
    output logic [way_bits(WAY)-1:0]  victim
);

    localparam int SETS = 2 ** INDEX;

    generate
        if (WAY == 1) begin : g_direct
            assign victim = '0;
        end else begin : g_tree
            localparam int PW = plru_width(WAY);
            localparam int LV = $clog2(WAY);
            localparam logic [LV:0] ONE = 1;

            logic [PW-1:0] tree [SETS];
            logic [PW-1:0] cur;
            logic [PW-1:0] upd;

            assign cur = tree[set_idx];

            always_comb begin
                logic [LV-1:0] n;
                victim = '0;
                n      = '0;
                for (int l = 0; l < LV; l++) begin
                    victim[LV-1-l] = cur[n];
                    n = LV'({n, cur[n]} + ONE);
                end
            end

            // Point every node on the accessed path away from the accessed way.
            always_comb begin
                logic [LV-1:0] n;
                logic          dir;
                upd = cur;
                n   = '0;
                for (int l = 0; l < LV; l++) begin
                    dir    = touch_way[LV-1-l];
                    upd[n] = ~dir;
                    n      = LV'({n, dir} + ONE);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < SETS; s++) tree[s] <= '0;
                end else if (touch) begin
                    tree[set_idx] <= upd;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache.
// One lookup per cycle in IDLE; a miss stalls the core, writes back a dirty
// victim word by word, refills the line word by word, then replays as a hit.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   req, data_addr        : core access valid / byte address (bits [1:0] ignored)
//   data_write, is_write  : store data / 1=store, 0=load
//   stall                 : core holds its request while high
//   data                  : load result (valid when req & !is_write & !stall)
//   mem_req, mem_we       : memory word request / 1=write-back, 0=refill
//   mem_addr, mem_wdata   : word-aligned memory address / write-back data
//   mem_rdata, mem_ack    : refill data / one word transferred this cycle
// Optional feature macro CACHE_PERF_CNT_EN adds saturating hit_count,
// miss_count and wb_count outputs.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int INDEX  = 7,
    parameter int OFFSET = 3,
    parameter int WAY    = 2,
    parameter int TAG    = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write,
    input  logic        is_write,
    output logic        stall,
    output logic [31:0] data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
`endif
);

    localparam int SETS  = 2 ** INDEX;
    localparam int WORDS = 2 ** OFFSET;
    localparam int WB    = way_bits(WAY);

    generate
        if (TAG != 32 - INDEX - OFFSET - 2) begin : g_bad_tag
            $error("set_assoc_cache: TAG must equal 32-INDEX-OFFSET-2");
        end
        if (WAY < 1 || WAY > 8 || (WAY & (WAY - 1)) != 0) begin : g_bad_way
            $error("set_assoc_cache: WAY must be a power of two in 1..8");
        end
    endgenerate

    logic [TAG-1:0]    req_tag;
    logic [INDEX-1:0]  req_idx;
    logic [OFFSET-1:0] req_word;

    assign req_tag  = TAG'(addr_tag(data_addr, INDEX, OFFSET));
    assign req_idx  = INDEX'(addr_index(data_addr, INDEX, OFFSET));
    assign req_word = OFFSET'(addr_word(data_addr, OFFSET));

    logic [TAG-1:0]  tag_arr   [WAY][SETS];
    logic [SETS-1:0] valid_arr [WAY];
    logic [SETS-1:0] dirty_arr [WAY];
    logic [31:0]     data_arr  [WAY][SETS][WORDS];

    cache_state_t      state;
    logic [OFFSET-1:0] word_cnt;
    logic [OFFSET-1:0] cnt_next;
    logic [WB-1:0]     victim_q;

    assign cnt_next = word_cnt + OFFSET'(1);

    // Lookup
    logic [WAY-1:0] hit_vec;
    logic [WB-1:0]  hit_way;
    logic           hit;
    logic           lookup_hit;
    logic           miss;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAY; w++) begin
            hit_vec[w] = valid_arr[w][req_idx] && (tag_arr[w][req_idx] == req_tag);
            if (hit_vec[w]) hit_way = WB'(w);
        end
    end

    assign hit        = |hit_vec;
    assign lookup_hit = req && (state == ST_IDLE) && hit;
    assign miss       = req && (state == ST_IDLE) && !hit;

    // Victim: lowest-numbered invalid way, otherwise the pseudo-LRU way
    logic          has_invalid;
    logic [WB-1:0] first_invalid;
    logic [WB-1:0] plru_victim;
    logic [WB-1:0] victim_way;
    logic          victim_dirty;

    always_comb begin
        has_invalid   = 1'b0;
        first_invalid = '0;
        for (int w = WAY - 1; w >= 0; w--) begin
            if (!valid_arr[w][req_idx]) begin
                has_invalid   = 1'b1;
                first_invalid = WB'(w);
            end
        end
    end

    assign victim_way   = has_invalid ? first_invalid : plru_victim;
    assign victim_dirty = valid_arr[victim_way][req_idx] && dirty_arr[victim_way][req_idx];

    // Replacement state
    logic          fill_last;
    logic          plru_touch;
    logic [WB-1:0] plru_way;

    assign fill_last  = (state == ST_FILL) && mem_ack && (&word_cnt);
    assign plru_touch = lookup_hit || fill_last;
    assign plru_way   = lookup_hit ? hit_way : victim_q;

    cache_plru #(
        .WAY   (WAY),
        .INDEX (INDEX)
    ) u_plru (
        .clk       (clk),
        .reset     (reset),
        .set_idx   (req_idx),
        .touch     (plru_touch),
        .touch_way (plru_way),
        .victim    (plru_victim)
    );

    // Core-side outputs
    assign stall = (state != ST_IDLE) || miss;
    assign data  = (lookup_hit && !is_write) ? data_arr[hit_way][req_idx][req_word] : '0;

    // Miss-handling FSM with registered memory-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            victim_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int w = 0; w < WAY; w++) begin
                valid_arr[w] <= '0;
                dirty_arr[w] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lookup_hit && is_write) dirty_arr[hit_way][req_idx] <= 1'b1;
                    if (miss) begin
                        victim_q <= victim_way;
                        word_cnt <= '0;
                        mem_req  <= 1'b1;
                        if (victim_dirty) begin
                            state     <= ST_WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= line_addr(32'(tag_arr[victim_way][req_idx]),
                                                   32'(req_idx), 32'd0, INDEX, OFFSET);
                            mem_wdata <= data_arr[victim_way][req_idx][0];
                        end else begin
                            state    <= ST_FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= line_addr(32'(req_tag), 32'(req_idx), 32'd0,
                                                  INDEX, OFFSET);
                        end
                    end
                end
                ST_WB: begin
                    if (mem_ack) begin
                        word_cnt <= cnt_next;
                        if (&word_cnt) begin
                            state    <= ST_FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= line_addr(32'(req_tag), 32'(req_idx), 32'd0,
                                                  INDEX, OFFSET);
                        end else begin
                            mem_addr  <= line_addr(32'(tag_arr[victim_q][req_idx]),
                                                   32'(req_idx), 32'(cnt_next), INDEX, OFFSET);
                            mem_wdata <= data_arr[victim_q][req_idx][cnt_next];
                        end
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        word_cnt <= cnt_next;
                        if (&word_cnt) begin
                            state                       <= ST_DONE;
                            mem_req                     <= 1'b0;
                            valid_arr[victim_q][req_idx] <= 1'b1;
                            dirty_arr[victim_q][req_idx] <= 1'b0;
                        end else begin
                            mem_addr <= line_addr(32'(req_tag), 32'(req_idx), 32'(cnt_next),
                                                  INDEX, OFFSET);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (lookup_hit && is_write) data_arr[hit_way][req_idx][req_word] <= data_write;
        if ((state == ST_FILL) && mem_ack) data_arr[victim_q][req_idx][word_cnt] <= mem_rdata;
        if (fill_last) tag_arr[victim_q][req_idx] <= req_tag;
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (lookup_hit && (hit_count != '1)) hit_count <= hit_count + 32'd1;
            if (miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
            if (miss && victim_dirty && (wb_count != '1)) wb_count <= wb_count + 32'd1;
        end
    end
`endif

endmodule
